// File: rtl/fsquare_iter.sv
// Iterative IEEE-754 single squarer d = s*s. Fixed latency 25 cycles (13 with FSQUARE_RADIX4_EN);
// one op in flight, in_ready only in IDLE, result held in DONE until out_ready.
module fsquare_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d
);

`ifdef FSQUARE_RADIX4_EN
  localparam int CNT_W  = 4;
  localparam int LAST_I = 11;
`else
  localparam int CNT_W  = 5;
  localparam int LAST_I = 23;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

  state_t           state, state_nxt;
  logic [30:0]      s_r;
  logic [23:0]      m;
  logic [47:0]      prod;
  logic [CNT_W-1:0] cnt;
  logic [47:0]      pp;
  logic [31:0]      res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL;
      MUL:     if (cnt == LAST) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Partial product for the multiplier bit(s) retired this cycle
`ifdef FSQUARE_RADIX4_EN
  logic [1:0]  dig;
  logic [25:0] pp_m;
  always_comb begin
    dig = m[{cnt, 1'b0} +: 2];
    case (dig)
      2'd0:    pp_m = 26'd0;
      2'd1:    pp_m = {2'b00, m};
      2'd2:    pp_m = {1'b0, m, 1'b0};
      default: pp_m = {2'b00, m} + {1'b0, m, 1'b0};
    endcase
    pp = {22'd0, pp_m} << {cnt, 1'b0};
  end
`else
  always_comb begin
    pp = m[cnt] ? ({24'd0, m} << cnt) : 48'd0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r  <= '0;
      m    <= '0;
      prod <= '0;
      cnt  <= '0;
      d    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s_r  <= s[30:0];
          m    <= {1'b1, s[22:0]};
          prod <= '0;
          cnt  <= '0;
        end
        MUL: begin
          prod <= prod + pp;
          cnt  <= cnt + 1'b1;
        end
        ROUND:   d <= res;
        default: ;
      endcase
    end
  end

  // Normalise, round-to-nearest-even, then range/special selection
  logic        p_hi, g, st, inc;
  logic [22:0] frac_t, frac_f;
  logic [23:0] rnd;
  logic [7:0]  e_i;
  logic [9:0]  exp_c;

  always_comb begin
    p_hi   = prod[47];
    frac_t = p_hi ? prod[46:24] : prod[45:23];
    g      = p_hi ? prod[23] : prod[22];
    st     = p_hi ? (|prod[22:0]) : (|prod[21:0]);
    inc    = g & (st | frac_t[0]);
    rnd    = {1'b0, frac_t} + {23'd0, inc};
    frac_f = rnd[23] ? 23'd0 : rnd[22:0];
    e_i    = s_r[30:23];
    // 10-bit two's complement exponent; bit 9 set means negative
    exp_c  = {1'b0, e_i, 1'b0} - 10'd127 + {9'd0, p_hi} + {9'd0, rnd[23]};

    if (e_i == 8'd0)
      res = 32'h0000_0000;
    else if (e_i == 8'hFF)
      res = (s_r[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    else if (exp_c[9] || (exp_c == 10'd0))
      res = 32'h0000_0000;
    else if (exp_c >= 10'd255)
      res = 32'h7F80_0000;
    else
      res = {1'b0, exp_c[7:0], frac_f};
  end

endmodule

// File: tb/tb_fsquare_iter.sv
// Scoreboard bench for fsquare_iter: driver pushes expected results, negedge monitor pops and compares.
module tb_fsquare_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;

`ifdef FSQUARE_RADIX4_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 25;
`endif

  fsquare_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] exp;
    logic [31:0] acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  logic vld_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data on the handshake cycle
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got %h, want no output", d);
      end else begin
        if (!vld_prev) check("latency", 32'(cyc) - q[0].acc, 32'(LAT));
        if (out_ready) begin
          check("result", d, q[0].exp);
          void'(q.pop_front());
        end
      end
    end
    vld_prev = out_valid;
  end

  task automatic send(input logic [31:0] s_i, input logic [31:0] exp_i);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    s        = s_i;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, want 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    q.push_back({exp_i, 32'(cyc + 1)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
  endtask

  logic [31:0] vs[15];
  logic [31:0] ve[15];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hi;
    vs = '{32'h40000000, 32'h3FC00000, 32'h40400000, 32'hC0000000, 32'h3F800001,
           32'h3FFFFFFF, 32'h3F800800, 32'h3F800E00, 32'h5F800000, 32'h1F800000,
           32'h20000000, 32'h7F800000, 32'h7F800001, 32'h80000000, 32'h00000001};
    ve = '{32'h40800000, 32'h40100000, 32'h41100000, 32'h40800000, 32'h3F800002,
           32'h407FFFFE, 32'h3F801000, 32'h3F801C02, 32'h7F800000, 32'h00000000,
           32'h00800000, 32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h00000000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    s         = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_d", d, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) send(vs[i], ve[i]);
    drain();

    // Backpressure: hold out_ready low for 10 cycles, offer a second operand meanwhile
    out_ready = 1'b0;
    send(32'h40400000, 32'h41100000);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      s        = 32'h40000000;
      @(negedge clk);
      check("stall_d", d, 32'h41100000);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset mid-multiply aborts the operation
    send(32'h40000000, 32'h40800000);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_d", d, 32'h0);
    n_hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) n_hi++;
    end
    check("abort_no_valid", 32'(n_hi), 32'd0);

    send(32'h3F800000, 32'h3F800000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fsquare_iter.md
Name: fsquare_iter

Overview:
- Multi-cycle IEEE-754 single-precision squaring unit: d = s*s.
- Performs the inverse of the square-root datapath. Used to re-square fsqrt results in self-check paths, and as a dedicated FPU square op.
- Iterative shift-add mantissa multiplier behind a valid/ready handshake on both sides, one operation in flight.

Parameters:
- none (latency is selected by the optional macro only)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand s is valid
- in_ready  out  1  unit can accept an operand (state==IDLE)
- s  in  32  operand, IEEE-754 single
- out_valid  out  1  result d is valid
- out_ready  in  1  consumer accepts d
- d  out  32  result, IEEE-754 single

Behaviour:
- Reset, asynchronous: state=IDLE, out_valid=0, d=32'h0, iteration counter=0, internal operand/product registers=0. in_ready=1 once state==IDLE.
- States: IDLE -> MUL -> ROUND -> DONE -> IDLE.
- IDLE: on in_valid&&in_ready at edge T0:
  - latch s, set m={1,s[22:0]} (24b), clear 48b product, counter=0, go to MUL.
- MUL: one multiplier bit per cycle, LSB first (add m<<i when m[i]), 24 cycles (edges T1..T24). Enter ROUND after the 24th.
- ROUND (edge T25): compute d, go to DONE.
  - out_valid is high from after T25: fixed latency of 25 cycles from the accepting edge, for every operand including specials.
- DONE: out_valid=1, d held stable until out_ready=1 at an edge. Then out_valid=0 and state goes to IDLE.
  - in_ready rises the following cycle; no same-cycle accept/return.
- in_valid while busy is ignored; the operand is not captured.
- Arithmetic, p=m*m, p in [2^46, 2^48):
  - p[47]=1: frac=p[46:24], G=p[23], S=|p[22:0], n=1.
  - p[47]=0: frac=p[45:23], G=p[22], S=|p[21:0], n=0.
  - E = 2*e - 127 + n, computed in 10-bit signed.
  - Round to nearest even: inc = G&&(S||frac[0]). Carry-out of frac+inc gives frac=0 and E+1.
  - E>=255 gives +inf 32'h7F800000. E<=0 gives +0 (flush, no subnormal output).
- Specials, decided in ROUND, where e=s[30:23]:
  - e==0 (zero/subnormal in) gives 32'h00000000.
  - e==255 with frac==0 gives 32'h7F800000.
  - e==255 with frac!=0 gives quiet NaN 32'h7FC00000.
- Result sign is always 0, since s*s is non-negative, including for negative s.
- rst asserted mid-MUL/ROUND/DONE: operation aborted, no out_valid pulse, state IDLE.

Optional Feature:
- Macro: FSQUARE_RADIX4_EN.
- Defined:
  - MUL retires two multiplier bits per cycle (adds 0, m, 2m or 3m shifted by 2i), 12 cycles.
  - Fixed latency is 13 cycles from the accepting edge.
  - Results are bit-identical to the radix-2 build.
- Undefined: radix-2, 24 MUL cycles, latency 25.

Test Plan:
- Basic and latency: s=32'h40000000 (2.0) -> d=32'h40800000. out_valid first high exactly 25 cycles after the accept edge (13 with FSQUARE_RADIX4_EN).
- Normalization: 1.5 (32'h3FC00000) -> 32'h40100000 (2.25). 3.0 (32'h40400000) -> 32'h41100000. -2.0 (32'hC0000000) -> 32'h40800000.
- Rounding: s=32'h3F800001 -> d=32'h3F800002. s=32'h3FFFFFFF -> 32'h407FFFFE.
- Range: 32'h5F800000 (2^64) -> 32'h7F800000. 32'h1F800000 (2^-64) -> 32'h00000000. 32'h20000000 (2^-63) -> 32'h00800000.
- Specials: 32'h7F800000 -> 32'h7F800000. 32'h7F800001 -> 32'h7FC00000. 32'h80000000 -> 32'h00000000. 32'h00000001 -> 32'h00000000.
- Handshake:
  - With out_ready=0 for 10 cycles after out_valid: d stable, in_ready=0, second in_valid ignored.
  - After out_ready: in_ready=1 the next cycle.
  - rst pulsed at MUL cycle 5: out_valid never rises, in_ready=1 after release.
